// File: rtl/fetch_queue.sv
// fetch_queue: IF stage owning the fetch PC and a DEPTH-entry prefetch queue of {instruction, PC+4}.
// Optional build macro FETCHQ_STATS_EN adds the FlushCount / FullCycles saturating statistics ports.
module fetch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic                       Clk,
  input  logic                       Reset,
  output logic [ADDR_W-1:0]          IMemAddr,
  input  logic [DATA_W-1:0]          IMemData,
  input  logic                       Redirect,
  input  logic [ADDR_W-1:0]          RedirectPC,
  input  logic                       Stall,
  output logic                       Valid,
  output logic [DATA_W-1:0]          InstrOut,
  output logic [ADDR_W-1:0]          PCPlus4Out,
  output logic [$clog2(DEPTH+1)-1:0] Count
`ifdef FETCHQ_STATS_EN
  ,
  output logic [31:0]                FlushCount,
  output logic [31:0]                FullCycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_p0;
  logic [PTR_W-1:0]  head_p0;
  logic [PTR_W-1:0]  tail_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic [DATA_W-1:0] instr_p0 [DEPTH];
  logic [ADDR_W-1:0] pc4_p0   [DEPTH];

  logic              full;
  logic              pop;
  logic              push;
  logic [ADDR_W-1:0] pc_plus4;

  always_comb begin
    full     = (cnt_p0 == FULL_CNT);
    pop      = (cnt_p0 != '0) & ~Stall & ~Redirect;
    push     = ~Redirect & (~full | pop);
    pc_plus4 = pc_p0 + ADDR_W'(4);
  end

  // ---- fetch / queue stage: PC register, ring storage, pointers and occupancy
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_p0   <= PC_RESET;
      head_p0 <= '0;
      tail_p0 <= '0;
      cnt_p0  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_p0[i] <= '0;
        pc4_p0[i]   <= '0;
      end
    end else if (Redirect) begin
      // The word on IMemData this cycle belongs to the wrong path and is dropped.
      pc_p0   <= RedirectPC;
      head_p0 <= '0;
      tail_p0 <= '0;
      cnt_p0  <= '0;
    end else begin
      if (pop)
        head_p0 <= head_p0 + PTR_W'(1);
      if (push) begin
        instr_p0[tail_p0] <= IMemData;
        pc4_p0[tail_p0]   <= pc_plus4;
        tail_p0           <= tail_p0 + PTR_W'(1);
        pc_p0             <= pc_plus4;
      end
      if (push && !pop)
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      else if (pop && !push)
        cnt_p0 <= cnt_p0 - CNT_W'(1);
    end
  end

  always_comb begin
    IMemAddr   = pc_p0;
    Valid      = (cnt_p0 != '0);
    InstrOut   = instr_p0[head_p0];
    PCPlus4Out = pc4_p0[head_p0];
    Count      = cnt_p0;
  end

`ifdef FETCHQ_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

  // ---- statistics stage
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      FlushCount <= '0;
      FullCycles <= '0;
    end else begin
      if (Redirect)
        FlushCount <= sat_add(FlushCount, 32'(cnt_p0));
      if (full && !pop)
        FullCycles <= sat_add(FullCycles, 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a queue-based reference model, plus directed literal checks.
// Stats ports are exercised when FETCHQ_STATS_EN is defined.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Stall;
  logic        Valid;
  logic [31:0] InstrOut;
  logic [31:0] PCPlus4Out;
  logic [2:0]  Count;

  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic [2:0]  w_count;
  logic        zero = 1'b0;
  logic [31:0] zero32 = 32'd0;

`ifdef FETCHQ_STATS_EN
  logic [31:0] FlushCount, FullCycles, w_flush, w_full;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a >> 2) * 32'h11;
  endfunction

  assign IMemData = imem(IMemAddr);
  assign w_data   = imem(w_addr);

  always #5 Clk = ~Clk;

  fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .PC_RESET(32'h0)) dut (
    .Clk(Clk), .Reset(Reset), .IMemAddr(IMemAddr), .IMemData(IMemData),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .Stall(Stall),
    .Valid(Valid), .InstrOut(InstrOut), .PCPlus4Out(PCPlus4Out), .Count(Count)
`ifdef FETCHQ_STATS_EN
    , .FlushCount(FlushCount), .FullCycles(FullCycles)
`endif
  );

  fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .PC_RESET(32'hFFFF_FFF8)) dut_w (
    .Clk(Clk), .Reset(Reset), .IMemAddr(w_addr), .IMemData(w_data),
    .Redirect(zero), .RedirectPC(zero32), .Stall(zero),
    .Valid(w_valid), .InstrOut(w_instr), .PCPlus4Out(w_pc4), .Count(w_count)
`ifdef FETCHQ_STATS_EN
    , .FlushCount(w_flush), .FullCycles(w_full)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {instr, pc+4} entries driven by the handshake rules.
  typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } entry_t;
  entry_t      mq[$];
  logic [31:0] m_pc;
  longint      m_flush, m_full;
  bit          m_pop, m_push;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mq.delete();
      m_pc = 32'h0;
      m_flush = 0;
      m_full = 0;
    end else begin
      m_pop  = (mq.size() > 0) && !Stall && !Redirect;
      m_push = !Redirect && ((mq.size() < DEPTH) || m_pop);
      if (mq.size() == DEPTH && !m_pop) m_full = (m_full >= 64'hFFFF_FFFF) ? m_full : m_full + 1;
      if (Redirect) begin
        m_flush = m_flush + mq.size();
        if (m_flush > 64'hFFFF_FFFF) m_flush = 64'hFFFF_FFFF;
        mq.delete();
        m_pc = RedirectPC;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back('{instr: imem(m_pc), pc4: m_pc + 32'd4});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_on && !Reset) begin
      chk("m_valid", 64'(Valid), 64'(mq.size() != 0));
      chk("m_count", 64'(Count), 64'(mq.size()));
      chk("m_addr", 64'(IMemAddr), 64'(m_pc));
      if (mq.size() != 0) begin
        chk("m_instr", 64'(InstrOut), 64'(mq[0].instr));
        chk("m_pc4", 64'(PCPlus4Out), 64'(mq[0].pc4));
      end
`ifdef FETCHQ_STATS_EN
      chk("m_flush", 64'(FlushCount), 64'(m_flush));
      chk("m_full", 64'(FullCycles), 64'(m_full));
`endif
    end
  end

  task automatic do_reset(input logic stall_v);
    @(posedge Clk); #2;
    Reset = 1'b1; Stall = stall_v; Redirect = 1'b0;
    @(posedge Clk); #2;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
    repeat (2) @(posedge Clk);
    @(negedge Clk); #1;
    chk("rst_valid", 64'(Valid), 64'd0);
    chk("rst_count", 64'(Count), 64'd0);
    chk("rst_instr", 64'(InstrOut), 64'd0);
    chk("rst_pc4", 64'(PCPlus4Out), 64'd0);
    chk("rst_addr", 64'(IMemAddr), 64'd0);
    chk("rst_waddr", 64'(w_addr), 64'hFFFF_FFF8);
    chk_on = 1;

    // sequential fetch from reset, plus wrap-around on the second instance
    @(posedge Clk); #2; Reset = 1'b0;
    @(negedge Clk); #1;
    chk("t1_addr0", 64'(IMemAddr), 64'd0);
    chk("t1_valid0", 64'(Valid), 64'd0);
    @(negedge Clk); #1;
    chk("t1_valid1", 64'(Valid), 64'd1);
    chk("t1_instr1", 64'(InstrOut), 64'h00);
    chk("t1_pc4_1", 64'(PCPlus4Out), 64'd4);
    chk("t1_addr1", 64'(IMemAddr), 64'd4);
    chk("t5_waddr1", 64'(w_addr), 64'hFFFF_FFFC);
    chk("t5_wpc4_1", 64'(w_pc4), 64'hFFFF_FFFC);
    @(negedge Clk); #1;
    chk("t1_instr2", 64'(InstrOut), 64'h11);
    chk("t1_pc4_2", 64'(PCPlus4Out), 64'd8);
    chk("t5_waddr2", 64'(w_addr), 64'h0);
    chk("t5_wpc4_2", 64'(w_pc4), 64'h0);
    @(negedge Clk); #1;
    chk("t1_instr3", 64'(InstrOut), 64'h22);
    chk("t1_pc4_3", 64'(PCPlus4Out), 64'd12);
    chk("t5_waddr3", 64'(w_addr), 64'h4);

    // stall fills the queue and holds
    do_reset(1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge Clk); @(negedge Clk); #1;
      chk("t2_count", 64'(Count), 64'((k < DEPTH) ? k : DEPTH));
    end
    chk("t2_addr", 64'(IMemAddr), 64'h10);
    chk("t2_pc4", 64'(PCPlus4Out), 64'd4);
    chk("t2_instr", 64'(InstrOut), 64'h0);
`ifdef FETCHQ_STATS_EN
    chk("t2_fullcyc", 64'(FullCycles), 64'd6);
`endif

    // one-cycle stall release while full
    Stall = 1'b0;
    @(posedge Clk); #2; Stall = 1'b1;
    @(negedge Clk); #1;
    chk("t3_count", 64'(Count), 64'd4);
    chk("t3_addr", 64'(IMemAddr), 64'h14);
    chk("t3_pc4", 64'(PCPlus4Out), 64'd8);
    chk("t3_instr", 64'(InstrOut), 64'h11);
`ifdef FETCHQ_STATS_EN
    chk("t3_fullcyc", 64'(FullCycles), 64'd6);
    @(negedge Clk); #1;
    chk("t3_fullcyc2", 64'(FullCycles), 64'd7);
`endif

    // redirect under stall with three entries queued
    do_reset(1'b1);
    repeat (3) @(posedge Clk);
    #2; Redirect = 1'b1; RedirectPC = 32'h100;
    @(posedge Clk); #2; Redirect = 1'b0;
    @(negedge Clk); #1;
    chk("t4_count", 64'(Count), 64'd0);
    chk("t4_valid", 64'(Valid), 64'd0);
    chk("t4_addr", 64'(IMemAddr), 64'h100);
`ifdef FETCHQ_STATS_EN
    chk("t4_flush", 64'(FlushCount), 64'd3);
`endif
    @(negedge Clk); #1;
    chk("t4_valid2", 64'(Valid), 64'd1);
    chk("t4_instr", 64'(InstrOut), 64'h440);
    chk("t4_pc4", 64'(PCPlus4Out), 64'h104);

    // asynchronous reset between edges
    do_reset(1'b1);
    repeat (2) @(posedge Clk);
    #2;
    chk("t6_pre_count", 64'(Count), 64'd2);
    Reset = 1'b1;
    #1;
    chk("t6_valid", 64'(Valid), 64'd0);
    chk("t6_count", 64'(Count), 64'd0);
    chk("t6_instr", 64'(InstrOut), 64'd0);
    chk("t6_pc4", 64'(PCPlus4Out), 64'd0);
    chk("t6_addr", 64'(IMemAddr), 64'd0);
    @(posedge Clk); #2; Reset = 1'b0;

    // randomised traffic
    for (int i = 0; i < 2000; i++) begin
      @(posedge Clk); #2;
      Stall      = ($urandom_range(0, 99) < 45);
      Redirect   = ($urandom_range(0, 99) < 7);
      RedirectPC = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_0FFC);
      Reset      = (i == 1000);
    end
    @(posedge Clk); #2; Redirect = 1'b0; Stall = 1'b0;
    @(negedge Clk); #1;
    chk_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
